// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - vector/handshake/result bundle between the sweeper and its host
interface truth_table_sweeper_if;
    logic        start;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        x;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic        mismatch;
    logic [3:0]  fail_idx;
    logic [4:0]  fail_count;

    modport master (
        input  start,
        input  x,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output truth_table,
        output mismatch,
        output fail_idx,
        output fail_count
    );

    modport slave (
        output start,
        output x,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  truth_table,
        input  mismatch,
        input  fail_idx,
        input  fail_count
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - steps a 4-input function block through codes 0..15 and captures its truth table
// Optional compare against EXPECTED is built only when SWEEP_CHECK_EN is defined.
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;

    logic        accept;
    logic        capture;
    logic        busy_w;

    assign busy_w  = (state_q == SETTLE);
    assign accept  = (state_q == IDLE) && bus.start;
    assign capture = busy_w && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            table_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETTLE;
                    idx_d   = 4'd0;
                    cnt_d   = 8'd0;
                    table_d = 16'h0000;
                end
            end
            SETTLE: begin
                if (capture) begin
                    table_d[idx_q] = bus.x;
                    cnt_d          = 8'd0;
                    // idx stops at 15 so a sweep never wraps back onto code 0
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.a           = busy_w & idx_q[3];
    assign bus.b           = busy_w & idx_q[2];
    assign bus.c           = busy_w & idx_q[1];
    assign bus.d           = busy_w & idx_q[0];
    assign bus.busy        = busy_w;
    assign bus.done        = (state_q == DONE);
    assign bus.truth_table = table_q;

`ifdef SWEEP_CHECK_EN
    logic [4:0] fail_count_q, fail_count_d;
    logic [3:0] fail_idx_q, fail_idx_d;
    logic       miss;

    assign miss = capture && (bus.x != EXPECTED[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_count_q <= 5'd0;
            fail_idx_q   <= 4'd0;
        end else begin
            fail_count_q <= fail_count_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    always_comb begin
        fail_count_d = fail_count_q;
        fail_idx_d   = fail_idx_q;
        if (accept) begin
            fail_count_d = 5'd0;
            fail_idx_d   = 4'd0;
        end else if (miss) begin
            fail_count_d = fail_count_q + 5'd1;
            // codes are visited in ascending order, so the first miss is the lowest
            if (fail_count_q == 5'd0) begin
                fail_idx_d = idx_q;
            end
        end
    end

    assign bus.mismatch   = (fail_count_q != 5'd0);
    assign bus.fail_idx   = fail_idx_q;
    assign bus.fail_count = fail_count_q;
`else
    wire unused_expected = ^EXPECTED ^ accept;

    assign bus.mismatch   = 1'b0;
    assign bus.fail_idx   = 4'd0;
    assign bus.fail_count = 5'd0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper with x=(a&b)|c
module tb_truth_table_sweeper;
    localparam int NI = 5;

    typedef struct {
        int          k;
        logic [15:0] tbl;
        logic        mm;
        logic [3:0]  fi;
        logic [4:0]  fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [NI-1:0] start_v = '0;

    logic [3:0]  vec_w  [NI];
    logic        busy_w [NI];
    logic        done_w [NI];
    logic [15:0] tbl_w  [NI];
    logic        mm_w   [NI];
    logic [3:0]  fi_w   [NI];
    logic [4:0]  fc_w   [NI];

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    truth_table_sweeper_if bus [NI] ();

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            localparam int          S_G = (g == 1) ? 1 : 2;
            localparam logic [15:0] E_G = (g == 2) ? 16'hFCCE :
                                          (g == 3) ? 16'hFCCC :
                                          (g == 4) ? 16'h0333 : 16'h0000;
            truth_table_sweeper #(
                .SETTLE_CYCLES(S_G),
                .EXPECTED     (E_G)
            ) u_dut (
                .clk  (clk),
                .rst_n(rst_n),
                .bus  (bus[g])
            );
            assign bus[g].x     = (bus[g].a & bus[g].b) | bus[g].c;
            assign bus[g].start = start_v[g];
            assign vec_w[g]  = {bus[g].a, bus[g].b, bus[g].c, bus[g].d};
            assign busy_w[g] = bus[g].busy;
            assign done_w[g] = bus[g].done;
            assign tbl_w[g]  = bus[g].truth_table;
            assign mm_w[g]   = bus[g].mismatch;
            assign fi_w[g]   = bus[g].fail_idx;
            assign fc_w[g]   = bus[g].fail_count;
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] expected_of(input int k);
        case (k)
            2:       return 16'hFCCE;
            3:       return 16'hFCCC;
            4:       return 16'h0333;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic exp_t model(input int k);
        exp_t        e;
        logic [3:0]  code;
        logic [15:0] diff;
        e.k   = k;
        e.tbl = '0;
        for (int i = 0; i < 16; i++) begin
            code     = 4'(i);
            e.tbl[i] = (code[3] & code[2]) | code[1];
        end
        e.mm = 1'b0;
        e.fi = 4'd0;
        e.fc = 5'd0;
`ifdef SWEEP_CHECK_EN
        diff = e.tbl ^ expected_of(k);
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) begin
                e.fc = e.fc + 5'd1;
                e.fi = 4'(i);
            end
        end
        e.mm = (e.fc != 5'd0);
`else
        diff = expected_of(k);
        if (diff == 16'hFFFF) e.fc = 5'd0;
`endif
        return e;
    endfunction

    task automatic run_sweep(input int k, input int s, input int restart_at);
        exp_t        e;
        exp_t        got;
        int          busy_n = 0;
        int          done_n = 0;
        int          done_t = -1;
        int          vec_err = 0;
        int          tbl_err = 0;
        int          overlap = 0;
        logic [16:0] m17;
        logic [3:0]  exp_vec;
        e = model(k);
        @(negedge clk);
        start_v[k] = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        for (int t = 0; t <= 16 * s + 2; t++) begin
            if (busy_w[k]) busy_n++;
            if (done_w[k]) begin
                done_n++;
                done_t = t;
                if (busy_w[k]) overlap++;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk($sformatf("done_tbl_k%0d", k), 32'(tbl_w[k]), 32'(got.tbl));
                    chk($sformatf("done_mm_k%0d", k),  32'(mm_w[k]),  32'(got.mm));
                    chk($sformatf("done_fi_k%0d", k),  32'(fi_w[k]),  32'(got.fi));
                    chk($sformatf("done_fc_k%0d", k),  32'(fc_w[k]),  32'(got.fc));
                end
            end
            exp_vec = (t < 16 * s) ? 4'(t / s) : 4'd0;
            if (vec_w[k] !== exp_vec) vec_err++;
            if (t < 16 * s) begin
                m17 = (17'd1 << (t / s)) - 17'd1;
                if (tbl_w[k] !== (e.tbl & m17[15:0])) tbl_err++;
            end
            start_v[k] = (t == restart_at);
            @(posedge clk);
            #1;
        end
        start_v[k] = 1'b0;
        if (done_n == 0 && sb.size() > 0) got = sb.pop_front();
        chk($sformatf("busy_cycles_k%0d", k), 32'(busy_n), 32'(16 * s));
        chk($sformatf("done_count_k%0d", k), 32'(done_n), 32'd1);
        chk($sformatf("done_time_k%0d", k), 32'(done_t), 32'(16 * s));
        chk($sformatf("vector_errs_k%0d", k), 32'(vec_err), 32'd0);
        chk($sformatf("partial_tbl_errs_k%0d", k), 32'(tbl_err), 32'd0);
        chk($sformatf("busy_done_overlap_k%0d", k), 32'(overlap), 32'd0);
        chk($sformatf("tbl_hold_k%0d", k), 32'(tbl_w[k]), 32'(e.tbl));
    endtask

    task automatic all_zero_scan(output int nz);
        nz = 0;
        for (int k = 0; k < NI; k++) begin
            if (vec_w[k] !== 4'd0 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 ||
                tbl_w[k] !== 16'd0 || mm_w[k] !== 1'b0 || fi_w[k] !== 4'd0 ||
                fc_w[k] !== 5'd0) nz++;
        end
    endtask

    initial begin
        int nz;
        int bad;
        int done_seen;

        // reset held while start toggles
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_v = 5'($urandom_range(0, 31));
            all_zero_scan(nz);
            bad += nz;
        end
        @(negedge clk);
        start_v = '0;
        chk("reset_outputs_zero", 32'(bad), 32'd0);
        rst_n = 1'b1;

        // full sweep, SETTLE_CYCLES=2
        run_sweep(0, 2, -1);
        chk("table_fccc", 32'(tbl_w[0]), 32'h0000FCCC);

        // start re-pulsed 10 cycles into the sweep
        run_sweep(0, 2, 10);

        // reset mid-sweep
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (11) @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        all_zero_scan(nz);
        chk("abort_outputs_zero", 32'(nz), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 2, -1);

        // minimum settle
        run_sweep(1, 1, -1);

        // compare variants
        run_sweep(2, 2, -1);
        run_sweep(3, 2, -1);
        run_sweep(4, 2, -1);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer for a 4-input combinational function block. On a start pulse it steps the block's inputs {a,b,c,d} through all 16 codes 0..15, waits a programmable settle time per code, samples output x, and assembles the 16-bit truth table. It sits beside the combinational module under test and replaces manual test-vector stepping in lab hardware. It can optionally compare the table against an expected value.

## Interface
- SETTLE_CYCLES, 2, cycles each vector is held before x is sampled; legal range 1..255
- EXPECTED, 16'h0000, expected truth table, bit i = x for code i; used only with SWEEP_CHECK_EN
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a sweep; honoured only in IDLE
- a, b, c, d  out  1 each  vector to the function block; a is MSB of code, d is LSB
- x  in  1  function block output; must be a function of a,b,c,d only
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- table  out  16  captured truth table, bit i = x for code i
- mismatch  out  1  table differs from EXPECTED
- fail_idx  out  4  lowest failing code
- fail_count  out  5  number of failing codes, 0..16

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE: {a,b,c,d}=0, busy=0, done=0. start=1 at a rising edge clears table/idx/cnt/check outputs and moves to SETTLE.
- SETTLE: {a,b,c,d}=idx; busy=1; cnt increments each cycle. At the edge where cnt==SETTLE_CYCLES-1, table[idx] <= x.
  - If idx==15, go to DONE.
  - Otherwise idx <= idx+1 and cnt <= 0.
- DONE: one cycle. done=1, busy=0, {a,b,c,d}=0. Then unconditionally IDLE.
- table, mismatch, fail_idx and fail_count hold their values until the next accepted start or reset. Bits not yet captured during a sweep read 0.
- start in SETTLE or DONE is ignored. It is not queued.
- Reset values: all outputs 0, state IDLE. Reset asserted mid-sweep aborts immediately and asynchronously. No done pulse is issued and there is no residual state.
- idx is 4 bits and cnt is 8 bits. idx never wraps past 15 within a sweep.

## Timing
- E0 = edge accepting start.
- The vector for code 0 is visible in the cycle after E0.
- Code i is held for exactly SETTLE_CYCLES cycles and captured at edge E0+(i+1)·SETTLE_CYCLES.
- busy is high for 16·SETTLE_CYCLES cycles.
- done is high in the single cycle after edge E0+16·SETTLE_CYCLES. busy and done never overlap.
- Sweep latency from start edge to done: 16·SETTLE_CYCLES+1 cycles.
- The earliest next start is accepted at the edge that ends the DONE cycle +1, i.e. the first IDLE cycle.
- x is sampled synchronously. The combinational path delay must be less than SETTLE_CYCLES clock periods.

## Configuration
- SWEEP_CHECK_EN defined:
  - At each capture edge, x is compared with EXPECTED[idx].
  - On a difference, fail_count increments; if this is the first failure, fail_idx <= idx.
  - mismatch = (fail_count != 0).
  - All three are cleared on an accepted start and are final by the done cycle.
- SWEEP_CHECK_EN undefined: no comparison logic is built. mismatch, fail_idx and fail_count are tied to 0. The ports remain present.

## Test plan
- Reset: hold rst_n=0 with start toggling -> all outputs 0, busy never asserts.
- Full sweep:
  - Setup: SETTLE_CYCLES=2, DUT model x=(a&b)|c, one-cycle start pulse.
  - Expect: busy high for 32 cycles; a,b,c,d step 0..15, each held 2 cycles; done pulses once 33 cycles after E0; table=16'hFCCC.
- Start while busy: re-pulse start 10 cycles into the sweep -> no restart, single done at E0+33, table=16'hFCCC.
- Reset mid-sweep: drop rst_n 12 cycles after E0 -> outputs go to 0 immediately with no done pulse. After release, a new start gives a complete sweep with table=16'hFCCC.
- Minimum settle: SETTLE_CYCLES=1 -> vector changes every cycle, done 17 cycles after E0, table=16'hFCCC.
- Check feature (SWEEP_CHECK_EN defined):
  - EXPECTED=16'hFCCE -> mismatch=1, fail_idx=1, fail_count=1.
  - EXPECTED=16'hFCCC -> all three outputs 0.
  - EXPECTED=16'h0333 -> fail_count=16, fail_idx=0.
